// File: rtl/load_store_unit.sv
// load_store_unit: rv32i data-memory access stage. Handles one load/store at a time,
// rejects illegal or misaligned requests without touching memory, registers every output.
module load_store_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_we_i,
  input  logic [2:0]      req_funct3_i,
  input  logic [XLEN-1:0] req_addr_i,
  input  logic [XLEN-1:0] req_wdata_i,
  output logic            rsp_valid_o,
  output logic [XLEN-1:0] rsp_rdata_o,
  output logic            rsp_err_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [3:0]      mem_be_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t     state;
  logic       we_q;
  logic [2:0] funct3_q;
  logic [1:0] offset_q;

  function automatic logic is_legal(input logic we, input logic [2:0] f3);
    logic ok;
    if (we) begin
      ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
    end else begin
      case (f3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ok = 1'b1;
        default:                                ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

  // funct3[1:0] encodes the access size for both loads and stores
  function automatic logic is_aligned(input logic [2:0] f3, input logic [1:0] off);
    logic ok;
    case (f3[1:0])
      2'b00:   ok = 1'b1;
      2'b01:   ok = ~off[0];
      2'b10:   ok = (off == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] byte_enables(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = 4'b0011 << {off[1], 1'b0};
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [XLEN-1:0] store_data(input logic [2:0] f3, input logic [XLEN-1:0] wd);
    logic [XLEN-1:0] d;
    case (f3[1:0])
      2'b00:   d = {4{wd[7:0]}};
      2'b01:   d = {2{wd[15:0]}};
      2'b10:   d = wd;
      default: d = {XLEN{1'b0}};
    endcase
    return d;
  endfunction

  function automatic logic [XLEN-1:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                                   input logic [XLEN-1:0] rd);
    logic [XLEN-1:0] s;
    logic [XLEN-1:0] r;
    s = rd >> {off, 3'b000};
    case (f3)
      3'b000:  r = {{(XLEN-8){s[7]}}, s[7:0]};
      3'b001:  r = {{(XLEN-16){s[15]}}, s[15:0]};
      3'b010:  r = s;
      3'b100:  r = {{(XLEN-8){1'b0}}, s[7:0]};
      3'b101:  r = {{(XLEN-16){1'b0}}, s[15:0]};
      default: r = {XLEN{1'b0}};
    endcase
    return r;
  endfunction

  // Transaction sequencer; all interface outputs are registered here
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      we_q        <= 1'b0;
      funct3_q    <= 3'b000;
      offset_q    <= 2'b00;
      req_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= {XLEN{1'b0}};
      rsp_err_o   <= 1'b0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= {XLEN{1'b0}};
      mem_be_o    <= 4'b0000;
      mem_wdata_o <= {XLEN{1'b0}};
    end else begin
      rsp_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            we_q        <= req_we_i;
            funct3_q    <= req_funct3_i;
            offset_q    <= req_addr_i[1:0];
            req_ready_o <= 1'b0;
            if (is_legal(req_we_i, req_funct3_i) && is_aligned(req_funct3_i, req_addr_i[1:0])) begin
              state       <= REQ;
              mem_req_o   <= 1'b1;
              mem_we_o    <= req_we_i;
              mem_addr_o  <= {req_addr_i[XLEN-1:2], 2'b00};
              mem_be_o    <= byte_enables(req_funct3_i, req_addr_i[1:0]);
              mem_wdata_o <= store_data(req_funct3_i, req_wdata_i);
            end else begin
              state       <= RESP;
              rsp_valid_o <= 1'b1;
              rsp_err_o   <= 1'b1;
              rsp_rdata_o <= {XLEN{1'b0}};
            end
          end else begin
            req_ready_o <= 1'b1;
          end
        end
        REQ: begin
          if (mem_gnt_i) begin
            mem_req_o <= 1'b0;
            mem_we_o  <= 1'b0;
            if (we_q) begin
              state       <= RESP;
              rsp_valid_o <= 1'b1;
              rsp_err_o   <= 1'b0;
              rsp_rdata_o <= {XLEN{1'b0}};
            end else begin
              state <= WAIT;
            end
          end else begin
            state <= REQ;
          end
        end
        WAIT: begin
          if (mem_rvalid_i) begin
            state       <= RESP;
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= 1'b0;
            rsp_rdata_o <= load_extract(funct3_q, offset_q, mem_rdata_i);
          end else begin
            state <= WAIT;
          end
        end
        RESP: begin
          state       <= IDLE;
          req_ready_o <= 1'b1;
        end
        default: begin
          state       <= IDLE;
          req_ready_o <= 1'b1;
          mem_req_o   <= 1'b0;
          mem_we_o    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and randomized checks of load_store_unit against an
// arithmetic reference model of the RISC-V load/store rules.
module tb_load_store_unit;

  logic        clk, rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int vectors = 0;
  int miscompares = 0;

  // observations recorded by run_txn
  logic        o_ready0, o_req1, o_we1, o_unstable, o_err, o_ready_after;
  logic [31:0] o_addr1, o_wdata1, o_rdata, o_rdata_after;
  logic [3:0]  o_be1;
  int          o_req_cycles, o_lat, o_pulses;

  load_store_unit #(.XLEN(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_funct3_i(req_funct3), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_be_o(mem_be),
    .mem_wdata_o(mem_wdata), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
    .mem_rdata_i(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int m_size(input logic [2:0] f3);
    int s;
    case (f3 % 4)
      0: s = 1;
      1: s = 2;
      default: s = 4;
    endcase
    return s;
  endfunction

  function automatic bit m_ok(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    bit legal;
    legal = we ? (f3 <= 2) : (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
    return legal && ((addr % m_size(f3)) == 0);
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] addr);
    longint v;
    v = ((longint'(1) << m_size(f3)) - 1) << (addr % 4);
    return 4'(v);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
    longint v;
    if (m_size(f3) == 1) v = (longint'(wd) % 256) * 64'h0101_0101;
    else if (m_size(f3) == 2) v = (longint'(wd) % 65536) * 64'h0001_0001;
    else v = longint'(wd);
    return 32'(v);
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr,
                                         input logic [31:0] rd);
    longint v, span;
    int sz;
    sz = m_size(f3);
    v = longint'(rd) / (longint'(1) << (8 * (addr % 4)));
    if (sz < 4) begin
      span = longint'(1) << (8 * sz);
      v = v % span;
      if (f3 < 4 && v >= span / 2) v = v - span;
    end
    return 32'(v);
  endfunction

  // ---------------- driver + memory responder ----------------
  task automatic run_txn(input logic we_v, input logic [2:0] f3_v, input logic [31:0] addr_v,
                         input logic [31:0] wdata_v, input int gnt_dly, input int rv_dly,
                         input logic [31:0] rdata_v);
    logic granted, delivered;
    int gcnt, gk;
    granted = 1'b0; delivered = 1'b0; gcnt = 0; gk = 0;
    o_ready0 = req_ready; o_req1 = 1'b0; o_we1 = 1'b0; o_addr1 = 32'h0; o_be1 = 4'h0;
    o_wdata1 = 32'h0; o_unstable = 1'b0; o_req_cycles = 0; o_lat = -1; o_rdata = 32'h0;
    o_err = 1'b0; o_pulses = 0; o_ready_after = 1'b0; o_rdata_after = 32'h0;
    req_valid = 1'b1; req_we = we_v; req_funct3 = f3_v; req_addr = addr_v; req_wdata = wdata_v;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      req_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
      if (k == 1) begin
        o_req1 = mem_req; o_we1 = mem_we; o_addr1 = mem_addr; o_be1 = mem_be; o_wdata1 = mem_wdata;
      end
      if (mem_req) begin
        o_req_cycles++;
        if (mem_we !== o_we1 || mem_addr !== o_addr1 || mem_be !== o_be1 || mem_wdata !== o_wdata1)
          o_unstable = 1'b1;
      end
      if (rsp_valid) begin
        o_pulses++;
        if (o_lat < 0) begin o_lat = k; o_rdata = rsp_rdata; o_err = rsp_err; end
      end
      if (o_lat >= 0 && k > o_lat) begin
        o_ready_after = req_ready; o_rdata_after = rsp_rdata;
        break;
      end
      if (mem_req && !granted) begin
        // rvalid with junk data alongside the grant must be ignored
        if (gcnt == gnt_dly) begin mem_gnt = 1'b1; mem_rvalid = 1'b1; granted = 1'b1; gk = k; end
        else gcnt++;
      end else if (granted && !we_v && !delivered && (k - gk - 1) == rv_dly) begin
        mem_rvalid = 1'b1; mem_rdata = rdata_v; delivered = 1'b1;
      end
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; #2;
    if (req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b exp 1", req_ready); end
    vectors++;
    if ({rsp_valid, rsp_err, mem_req, mem_we} !== 4'b0000) begin
      miscompares++; $display("FAIL reset_flags got %b exp 0000", {rsp_valid, rsp_err, mem_req, mem_we});
    end
    vectors++;
    if (rsp_rdata !== 32'h0) begin miscompares++; $display("FAIL reset_rdata got %h exp 0", rsp_rdata); end
    vectors++;
    if (mem_addr !== 32'h0) begin miscompares++; $display("FAIL reset_addr got %h exp 0", mem_addr); end
    vectors++;
    if (mem_be !== 4'h0) begin miscompares++; $display("FAIL reset_be got %h exp 0", mem_be); end
    vectors++;
    if (mem_wdata !== 32'h0) begin miscompares++; $display("FAIL reset_wdata got %h exp 0", mem_wdata); end
    vectors++;
    @(posedge clk); @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
    if ({req_ready, rsp_valid, mem_req} !== 3'b100) begin
      miscompares++; $display("FAIL post_reset_idle got %b exp 100", {req_ready, rsp_valid, mem_req});
    end
    vectors++;
  endtask

  task automatic test_loads();
    logic [2:0]  f3s[4]  = '{3'b010, 3'b000, 3'b100, 3'b101};
    logic [31:0] adrs[4] = '{32'h100, 32'h103, 32'h103, 32'h102};
    logic [31:0] rds[4]  = '{32'hDEAD_BEEF, 32'h80FF_FF00, 32'h80FF_FF00, 32'h80FF_FF00};
    logic [3:0]  bes[4]  = '{4'b1111, 4'b1000, 4'b1000, 4'b1100};
    logic [31:0] exps[4] = '{32'hDEAD_BEEF, 32'hFFFF_FF80, 32'h0000_0080, 32'h0000_80FF};
    for (int i = 0; i < 4; i++) begin
      run_txn(1'b0, f3s[i], adrs[i], 32'h0, 0, 0, rds[i]);
      if (o_lat !== 3) begin miscompares++; $display("FAIL load%0d_latency got %0d exp 3", i, o_lat); end
      vectors++;
      if (o_addr1 !== 32'h100) begin miscompares++; $display("FAIL load%0d_addr got %h exp 100", i, o_addr1); end
      vectors++;
      if (o_be1 !== bes[i]) begin miscompares++; $display("FAIL load%0d_be got %b exp %b", i, o_be1, bes[i]); end
      vectors++;
      if ({o_rdata, o_err} !== {exps[i], 1'b0}) begin
        miscompares++; $display("FAIL load%0d_rdata got %h err %b exp %h err 0", i, o_rdata, o_err, exps[i]);
      end
      vectors++;
    end
  endtask

  task automatic test_store_delayed();
    run_txn(1'b1, 3'b000, 32'h201, 32'h1234_5678, 3, 0, 32'h0);
    if ({o_req1, o_we1, o_be1} !== {1'b1, 1'b1, 4'b0010}) begin
      miscompares++; $display("FAIL sb_req_we_be got %b exp 110010", {o_req1, o_we1, o_be1});
    end
    vectors++;
    if (o_wdata1 !== 32'h7878_7878) begin miscompares++; $display("FAIL sb_wdata got %h exp 78787878", o_wdata1); end
    vectors++;
    if (o_addr1 !== 32'h200) begin miscompares++; $display("FAIL sb_addr got %h exp 200", o_addr1); end
    vectors++;
    if (o_unstable !== 1'b0 || o_req_cycles !== 4) begin
      miscompares++; $display("FAIL sb_hold got unstable=%b cycles=%0d exp 0 4", o_unstable, o_req_cycles);
    end
    vectors++;
    if (o_lat !== 5 || o_rdata !== 32'h0 || o_err !== 1'b0) begin
      miscompares++; $display("FAIL sb_resp got lat=%0d rdata=%h err=%b exp 5 0 0", o_lat, o_rdata, o_err);
    end
    vectors++;
  endtask

  task automatic test_errors();
    run_txn(1'b1, 3'b001, 32'h203, 32'hAAAA_5555, 0, 0, 32'h0);
    if (o_req_cycles !== 0 || o_lat !== 1 || o_err !== 1'b1 || o_rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL sh_misaligned got req=%0d lat=%0d err=%b rdata=%h exp 0 1 1 0", o_req_cycles, o_lat, o_err, o_rdata);
    end
    vectors++;
    run_txn(1'b0, 3'b011, 32'h100, 32'h0, 0, 0, 32'h0);
    if (o_req_cycles !== 0 || o_lat !== 1 || o_err !== 1'b1 || o_rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL load_f3_011 got req=%0d lat=%0d err=%b rdata=%h exp 0 1 1 0", o_req_cycles, o_lat, o_err, o_rdata);
    end
    vectors++;
    if (o_rdata_after !== 32'h0 || o_ready_after !== 1'b1) begin
      miscompares++; $display("FAIL err_after got rdata=%h ready=%b exp 0 1", o_rdata_after, o_ready_after);
    end
    vectors++;
  endtask

  task automatic test_random();
    logic we_v; logic [2:0] f3_v; logic [31:0] a, wd, rd;
    int g, r, exp_lat;
    bit ok;
    for (int n = 0; n < 150; n++) begin
      we_v = 1'($urandom % 2); f3_v = 3'($urandom % 8); a = $urandom; wd = $urandom; rd = $urandom;
      g = $urandom % 4; r = $urandom % 4;
      ok = m_ok(we_v, f3_v, a);
      exp_lat = !ok ? 1 : (we_v ? g + 2 : g + r + 3);
      run_txn(we_v, f3_v, a, wd, g, r, rd);
      if (o_ready0 !== 1'b1 || o_lat !== exp_lat || o_pulses !== 1 || o_ready_after !== 1'b1) begin
        miscompares++;
        $display("FAIL rnd%0d_timing got ready0=%b lat=%0d pulses=%0d ready_after=%b exp 1 %0d 1 1",
                 n, o_ready0, o_lat, o_pulses, o_ready_after, exp_lat);
      end
      vectors++;
      if (o_err !== !ok || o_req_cycles !== (ok ? g + 1 : 0)) begin
        miscompares++;
        $display("FAIL rnd%0d_err got err=%b req_cycles=%0d exp %b %0d", n, o_err, o_req_cycles, !ok, ok ? g + 1 : 0);
      end
      vectors++;
      if (o_rdata !== ((ok && !we_v) ? m_load(f3_v, a, rd) : 32'h0)) begin
        miscompares++; $display("FAIL rnd%0d_rdata f3=%0d addr=%h got %h exp %h", n, f3_v, a, o_rdata,
                               (ok && !we_v) ? m_load(f3_v, a, rd) : 32'h0);
      end
      vectors++;
      if (ok) begin
        if (o_addr1 !== (a & 32'hFFFF_FFFC) || o_be1 !== m_be(f3_v, a) || o_we1 !== we_v || o_unstable !== 1'b0) begin
          miscompares++;
          $display("FAIL rnd%0d_memreq got addr=%h be=%b we=%b unstable=%b exp %h %b %b 0",
                   n, o_addr1, o_be1, o_we1, o_unstable, a & 32'hFFFF_FFFC, m_be(f3_v, a), we_v);
        end
        vectors++;
        if (we_v && o_wdata1 !== m_wdata(f3_v, wd)) begin
          miscompares++; $display("FAIL rnd%0d_wdata got %h exp %h", n, o_wdata1, m_wdata(f3_v, wd));
        end
        vectors++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [12:0] rdy, mreq, rval;
    logic [12:0] exp_rdy, exp_mreq, exp_rval;
    logic [31:0] rd3, rd7;
    logic gprev;
    rdy = '0; mreq = '0; rval = '0; gprev = 1'b0; rd3 = 32'h0; rd7 = 32'h0;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h40; req_wdata = 32'h0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (k == 5) req_valid = 1'b0;
      rdy[k] = req_ready; mreq[k] = mem_req; rval[k] = rsp_valid;
      if (k == 3) rd3 = rsp_rdata;
      if (k == 7) rd7 = rsp_rdata;
      mem_gnt = mem_req; mem_rvalid = gprev; mem_rdata = 32'h1111_0000 + 32'(k); gprev = mem_gnt;
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    exp_rdy = '0; exp_mreq = '0; exp_rval = '0;
    for (int k = 8; k <= 12; k++) exp_rdy[k] = 1'b1;
    exp_rdy[4] = 1'b1; exp_mreq[1] = 1'b1; exp_mreq[5] = 1'b1; exp_rval[3] = 1'b1; exp_rval[7] = 1'b1;
    if (rdy !== exp_rdy) begin miscompares++; $display("FAIL b2b_ready got %b exp %b", rdy, exp_rdy); end
    vectors++;
    if (mreq !== exp_mreq) begin miscompares++; $display("FAIL b2b_mem_req got %b exp %b", mreq, exp_mreq); end
    vectors++;
    if (rval !== exp_rval) begin miscompares++; $display("FAIL b2b_rsp_valid got %b exp %b", rval, exp_rval); end
    vectors++;
    if (rd3 !== 32'h1111_0002 || rd7 !== 32'h1111_0006) begin
      miscompares++; $display("FAIL b2b_rdata got %h %h exp 11110002 11110006", rd3, rd7);
    end
    vectors++;
  endtask

  task automatic test_reset_mid();
    int pulses;
    // reset while the request is outstanding
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h300;
    @(posedge clk); #1; req_valid = 1'b0;
    if (mem_req !== 1'b1) begin miscompares++; $display("FAIL rst_req_pre got %b exp 1", mem_req); end
    vectors++;
    #2 rst = 1'b1; #1;
    if ({mem_req, req_ready, rsp_valid} !== 3'b010) begin
      miscompares++; $display("FAIL rst_async got %b exp 010", {mem_req, req_ready, rsp_valid});
    end
    vectors++;
    @(posedge clk); #1; rst = 1'b0;
    // reset while waiting for read data, then a late rvalid
    req_valid = 1'b1;
    @(posedge clk); #1; req_valid = 1'b0; mem_gnt = 1'b1;
    @(posedge clk); #1; mem_gnt = 1'b0;
    #2 rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      mem_rvalid = (k < 2); mem_rdata = 32'hCAFE_0000 + 32'(k);
      @(posedge clk); #1;
      if (rsp_valid || mem_req) pulses++;
    end
    mem_rvalid = 1'b0;
    if (pulses !== 0) begin miscompares++; $display("FAIL rst_late_rvalid got %0d active cycles exp 0", pulses); end
    vectors++;
    run_txn(1'b0, 3'b001, 32'h502, 32'h0, 1, 2, 32'h7FFF_1234);
    if (o_lat !== 6 || o_rdata !== 32'h0000_7FFF || o_err !== 1'b0) begin
      miscompares++; $display("FAIL rst_recover got lat=%0d rdata=%h err=%b exp 6 00007fff 0", o_lat, o_rdata, o_err);
    end
    vectors++;
  endtask

  initial begin
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0; rst = 1'b0;
    test_reset();
    test_loads();
    test_store_delayed();
    test_errors();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Data-memory access stage of the rv32i core. Accepts one load or store request from the execute stage (funct3 encoded per the RISC-V LOAD/STORE funct3 fields), checks alignment, drives a word-addressed data-memory request/grant/rvalid interface with byte enables, and returns a sign- or zero-extended load result (or store completion) to writeback. Single outstanding transaction; no pipelining of requests.

## Interface
- XLEN, 32, data/address width; only 32 is supported.

- clk_i  in  1  clock; all state changes on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- req_valid_i  in  1  execute stage presents a request.
- req_ready_o  out  1  unit can accept; high only in IDLE.
- req_we_i  in  1  1 = store, 0 = load.
- req_funct3_i  in  3  LB/LH/LW/LBU/LHU (load) or SB/SH/SW (store) encoding.
- req_addr_i  in  XLEN  byte address (rs1 + imm, already summed).
- req_wdata_i  in  XLEN  store data (rs2), LSBs significant.
- rsp_valid_o  out  1  one-cycle pulse: transaction complete.
- rsp_rdata_o  out  XLEN  extended load data; 0 for stores and errors.
- rsp_err_o  out  1  misaligned address or illegal funct3; valid with rsp_valid_o.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  memory write.
- mem_addr_o  out  XLEN  word-aligned address ({addr[31:2], 2'b00}).
- mem_be_o  out  4  byte enables.
- mem_wdata_o  out  XLEN  lane-replicated store data.
- mem_gnt_i  in  1  memory accepts request this cycle.
- mem_rvalid_i  in  1  load data valid.
- mem_rdata_i  in  XLEN  load data word.

## Operation
- States: IDLE, REQ, WAIT, RESP.
- IDLE: req_ready_o=1. On req_valid_i: latch we, funct3, addr, wdata. Legal and aligned -> REQ; otherwise -> RESP with err=1 (no memory access).
- Legal: load funct3 in {000,001,010,100,101}; store in {000,001,010}. Others illegal.
- Aligned: byte ops any addr; half ops addr[0]=0; word ops addr[1:0]=00.
- REQ: mem_req_o=1, mem_* outputs registered and stable until grant. On mem_gnt_i: store -> RESP; load -> WAIT.
- WAIT: on mem_rvalid_i latch mem_rdata_i -> RESP.
- RESP: rsp_valid_o=1 for exactly one cycle, -> IDLE. No backpressure from writeback.
- Byte enables: SB/LB/LBU 4'b0001<<addr[1:0]; SH/LH/LHU 4'b0011<<{addr[1],1'b0}; SW/LW 4'b1111. Loads drive the same BE.
- Store data: SB {4{wdata[7:0]}}; SH {2{wdata[15:0]}}; SW wdata.
- Load extract: shift rdata right by 8*addr[1:0]; LB sign-extend bit 7, LBU zero-extend 8 bits, LH sign-extend bit 15, LHU zero-extend 16, LW unchanged.

## Timing
- Reset (async, immediate): state IDLE; req_ready_o=1; rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_be_o=0, mem_wdata_o=0.
- Accept at cycle 0 (req_valid_i & req_ready_o). mem_req_o high from cycle 1.
- Store, gnt in cycle 1: rsp_valid_o in cycle 2. Load, gnt cycle 1, rvalid cycle 2 earliest: rsp_valid_o cycle 3.
- Error: rsp_valid_o with rsp_err_o in cycle 1.
- Each cycle gnt is withheld adds one cycle; each cycle rvalid is withheld adds one cycle; no timeout.
- mem_rvalid_i in the same cycle as grant is ignored (rvalid only sampled in WAIT).
- mem_gnt_i/mem_rvalid_i outside REQ/WAIT ignored.
- Reset mid-transaction: mem_req_o drops asynchronously, transaction discarded, no rsp_valid_o; a late rvalid after reset is ignored.
- rsp_rdata_o/rsp_err_o hold their last value after RESP until the next RESP.

## Test plan
- LW addr 0x100, gnt cycle 1, rvalid cycle 2 rdata 0xDEADBEEF -> mem_addr 0x100, be 1111, rsp_valid cycle 3, rdata 0xDEADBEEF, err 0.
- LB addr 0x103, rdata 0x80FF_FF00 -> be 1000, rdata 0xFFFFFF80; LBU same -> 0x00000080; LHU addr 0x102 -> be 1100, 0x000080FF.
- SB addr 0x201 wdata 0x12345678, gnt delayed 3 cycles -> mem_req held with we=1, be 0010, wdata 0x78787878, addr 0x200 stable; rsp_valid 1 cycle after gnt, rdata 0.
- SH addr 0x203 -> no mem_req, rsp_valid cycle 1 with err 1; load funct3 011 -> same error.
- Back-to-back: req_valid held high across two LWs -> second accepted only in the IDLE cycle after RESP; req_ready_o low in REQ/WAIT/RESP.
- Assert rst_i in WAIT, then deliver rvalid after reset -> mem_req_o 0 immediately, no rsp_valid_o, next request completes normally.
